// File: rtl/ysyx_22041412_decode_stage_pkg.sv
// Shared definitions for the decode stage.
// Holds the RV opcode constants, the encodings of the small control fields
// (v1type, v2type, rv64_en, mem_mode, jump_mode), the decoded-bundle field
// widths, and the packed control bundle carried through the stage registers.
package ysyx_22041412_decode_stage_pkg;

   localparam int OPC_W   = 7;
   localparam int FUNC3_W = 3;
   localparam int FUNC7_W = 1;
   localparam int REG_W   = 5;
   localparam int INSTR_W = 32;

   localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;

   typedef enum logic [1:0] {V1_RS1 = 2'b00, V1_PC = 2'b01, V1_ZIMM = 2'b10} v1type_e;
   typedef enum logic       {V2_RS2 = 1'b0,  V2_IMM = 1'b1} v2type_e;
   typedef enum logic [1:0] {RV64_NONE = 2'b00, RV64_OP_IMM_32 = 2'b01, RV64_OP_32 = 2'b10} rv64_e;
   typedef enum logic [1:0] {MEM_IDLE = 2'b00, MEM_LOAD = 2'b01, MEM_STORE = 2'b10} mem_mode_e;
   typedef enum logic [1:0] {JMP_IDLE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10, JMP_BRANCH = 2'b11} jump_mode_e;

   // Instruction format; FMT_X marks an opcode this core does not execute.
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [FUNC3_W-1:0] func3;
      logic [FUNC7_W-1:0] func7;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [REG_W-1:0]   rd;
      v1type_e            v1type;
      v2type_e            v2type;
      logic               mul_en;
      logic               div_en;
      rv64_e              rv64_en;
      mem_mode_e          mem_mode;
      jump_mode_e         jump_mode;
      logic               illegal;
   } ctrl_t;

endpackage

// File: rtl/ysyx_22041412_decode_stage_if.sv
// Bus bundle of the decode stage: fetch-side handshake, flush, EXU-side
// handshake with the decoded fields, and the JAL redirect to fetch.
// Modports: slave = the decode stage, master = its environment (IFU/EXU).
interface ysyx_22041412_decode_stage_if #(
   parameter int XLEN = 64,
   parameter int PC_W = 32
);
   import ysyx_22041412_decode_stage_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   instr;
   logic [PC_W-1:0]      pc;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_pc;
   logic [OPC_W-1:0]     opcode;
   logic [FUNC3_W-1:0]   func3;
   logic [FUNC7_W-1:0]   func7;
   logic [REG_W-1:0]     rs1;
   logic [REG_W-1:0]     rs2;
   logic [REG_W-1:0]     rd;
   logic [XLEN-1:0]      imm;
   logic [1:0]           v1type;
   logic                 v2type;
   logic                 mul_en;
   logic                 div_en;
   logic [1:0]           rv64_en;
   logic [1:0]           mem_mode;
   logic [1:0]           jump_mode;
   logic                 illegal;
   logic                 redirect_valid;
   logic [XLEN-1:0]      redirect_pc;

   modport slave (
      input  in_valid, instr, pc, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, func3, func7, rs1, rs2, rd, imm,
             v1type, v2type, mul_en, div_en, rv64_en, mem_mode, jump_mode, illegal,
             redirect_valid, redirect_pc
   );

   modport master (
      output in_valid, instr, pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, func3, func7, rs1, rs2, rd, imm,
             v1type, v2type, mul_en, div_en, rv64_en, mem_mode, jump_mode, illegal,
             redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ysyx_22041412_decode_stage_comb.sv
// ysyx_22041412_decode_comb: purely combinational instruction decoder.
// Ports: instr/pc in; ctrl (control bundle), imm (sign-extended immediate)
// and pc_ext (zero-extended pc) out.
// Macro YSYX_22041412_RVM_EN: when defined, OP/OP-32 with funct7[0]=1 decode
// to mul_en/div_en; when undefined, funct7=0000001 on OP/OP-32 is illegal.
// An illegal instruction keeps opcode/func3/func7 but every other field is 0.
module ysyx_22041412_decode_comb
   import ysyx_22041412_decode_stage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [PC_W-1:0]    pc,
   output ctrl_t              ctrl,
   output logic [XLEN-1:0]    imm,
   output logic [XLEN-1:0]    pc_ext
);

   fmt_e             fmt;
   logic             m_illegal;
   logic [OPC_W-1:0] opc;

   assign opc    = instr[6:0];
   assign pc_ext = XLEN'(pc);

   always_comb begin
      case (opc)
         OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
         OPC_JAL:                                   fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: fmt = FMT_I;
         OPC_BRANCH:                                fmt = FMT_B;
         OPC_STORE:                                 fmt = FMT_S;
         OPC_OP:                                    fmt = FMT_R;
         OPC_OP_IMM_32:                             fmt = (XLEN == 64) ? FMT_I : FMT_X;
         OPC_OP_32:                                 fmt = (XLEN == 64) ? FMT_R : FMT_X;
         default:                                   fmt = FMT_X;
      endcase
   end

`ifdef YSYX_22041412_RVM_EN
   assign m_illegal = 1'b0;
`else
   assign m_illegal = (fmt == FMT_R) && (instr[31:25] == 7'b0000001);
`endif

   always_comb begin
      ctrl        = '0;
      imm         = '0;
      ctrl.opcode = opc;
      ctrl.func3  = instr[14:12];
      ctrl.func7  = instr[30];
      if (fmt == FMT_X || m_illegal) begin
         ctrl.illegal = 1'b1;
      end else begin
         ctrl.rs1 = (fmt == FMT_U || fmt == FMT_J) ? '0 : instr[19:15];
         ctrl.rs2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? instr[24:20] : '0;
         ctrl.rd  = (fmt == FMT_S || fmt == FMT_B) ? '0 : instr[11:7];
         case (fmt)
            FMT_I:   imm = XLEN'($signed(instr[31:20]));
            FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
         endcase
         ctrl.v2type = (fmt == FMT_R || fmt == FMT_B) ? V2_RS2 : V2_IMM;
         if (opc == OPC_AUIPC || opc == OPC_JAL)
            ctrl.v1type = V1_PC;
         else if (opc == OPC_SYSTEM && instr[14])
            ctrl.v1type = V1_ZIMM;   // csrr*i: rs1 field carries the zero-extended immediate
         else
            ctrl.v1type = V1_RS1;
         case (opc)
            OPC_LOAD:      ctrl.mem_mode  = MEM_LOAD;
            OPC_STORE:     ctrl.mem_mode  = MEM_STORE;
            OPC_JAL:       ctrl.jump_mode = JMP_JAL;
            OPC_JALR:      ctrl.jump_mode = JMP_JALR;
            OPC_BRANCH:    ctrl.jump_mode = JMP_BRANCH;
            OPC_OP_IMM_32: ctrl.rv64_en   = RV64_OP_IMM_32;
            OPC_OP_32:     ctrl.rv64_en   = RV64_OP_32;
            default:       ;
         endcase
`ifdef YSYX_22041412_RVM_EN
         ctrl.mul_en = (fmt == FMT_R) && instr[25] && !instr[14];
         ctrl.div_en = (fmt == FMT_R) && instr[25] &&  instr[14];
`endif
      end
   end

endmodule

// File: rtl/ysyx_22041412_decode_stage.sv
// ysyx_22041412_decode_stage: pipelined decode between IFU and EXU.
// Ports: clk, rst (async, active-high), bus (slave modport of
// ysyx_22041412_decode_stage_if).
// Decoded results land in the main entry one cycle after accept; a second
// (skid) entry absorbs the bundle accepted while main is stalled, so
// in_ready depends only on registered state. flush empties both entries and
// wins over a same-cycle EXU handshake. An accepted JAL produces a one-cycle
// redirect pulse carrying pc + imm.
// Macro YSYX_22041412_RVM_EN is honoured by the decoder sub-module.
module ysyx_22041412_decode_stage
   import ysyx_22041412_decode_stage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   ysyx_22041412_decode_stage_if.slave   bus
);

   ctrl_t           dec_ctrl, main_ctrl, skid_ctrl;
   logic [XLEN-1:0] dec_imm, dec_pc, main_imm, main_pc, skid_imm, skid_pc;
   logic [XLEN-1:0] redirect_pc_q;
   logic            main_valid, skid_full, redirect_valid_q;
   logic            accept, main_free, dec_is_jal;

   ysyx_22041412_decode_comb #(.XLEN(XLEN), .PC_W(PC_W)) u_decode_comb (
      .instr  (bus.instr),
      .pc     (bus.pc),
      .ctrl   (dec_ctrl),
      .imm    (dec_imm),
      .pc_ext (dec_pc)
   );

   assign accept     = bus.in_valid && !skid_full && !bus.flush;
   assign main_free  = !main_valid || bus.out_ready;
   assign dec_is_jal = (dec_ctrl.jump_mode == JMP_JAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid       <= 1'b0;
         skid_full        <= 1'b0;
         main_ctrl        <= '0;
         main_imm         <= '0;
         main_pc          <= '0;
         skid_ctrl        <= '0;
         skid_imm         <= '0;
         skid_pc          <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= accept && dec_is_jal;
         if (accept && dec_is_jal)
            redirect_pc_q <= dec_pc + dec_imm;
         if (bus.flush) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
         end else if (main_free) begin
            // skid_full implies in_ready=0, so skid and a new accept never compete
            if (skid_full) begin
               main_ctrl  <= skid_ctrl;
               main_imm   <= skid_imm;
               main_pc    <= skid_pc;
               main_valid <= 1'b1;
               skid_full  <= 1'b0;
            end else if (accept) begin
               main_ctrl  <= dec_ctrl;
               main_imm   <= dec_imm;
               main_pc    <= dec_pc;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_ctrl <= dec_ctrl;
            skid_imm  <= dec_imm;
            skid_pc   <= dec_pc;
            skid_full <= 1'b1;
         end
      end
   end

   assign bus.in_ready       = !skid_full;
   assign bus.out_valid      = main_valid;
   assign bus.out_pc         = main_pc;
   assign bus.imm            = main_imm;
   assign bus.opcode         = main_ctrl.opcode;
   assign bus.func3          = main_ctrl.func3;
   assign bus.func7          = main_ctrl.func7;
   assign bus.rs1            = main_ctrl.rs1;
   assign bus.rs2            = main_ctrl.rs2;
   assign bus.rd             = main_ctrl.rd;
   assign bus.v1type         = main_ctrl.v1type;
   assign bus.v2type         = main_ctrl.v2type;
   assign bus.mul_en         = main_ctrl.mul_en;
   assign bus.div_en         = main_ctrl.div_en;
   assign bus.rv64_en        = main_ctrl.rv64_en;
   assign bus.mem_mode       = main_ctrl.mem_mode;
   assign bus.jump_mode      = main_ctrl.jump_mode;
   assign bus.illegal        = main_ctrl.illegal;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22041412_decode_stage.sv
// Self-checking bench for ysyx_22041412_decode_stage (XLEN=64, PC_W=32).
// A behavioural model holds the bundles the stage should be holding as a
// queue (at most two), decodes instructions from the ISA field rules with
// plain arithmetic, and is compared against the DUT on every falling edge.
// Directed scenarios add literal expectations that pin the model.
module tb_ysyx_22041412_decode_stage;
   localparam int XLEN = 64;
   localparam int PC_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22041412_decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();
   ysyx_22041412_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic        func7;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm, pc;
      logic [1:0]  v1;
      logic        v2;
      logic        mul, div;
      logic [1:0]  rv64, mem, jmp;
      logic        illegal;
   } exp_t;

   exp_t        q[$];
   bit          rv_exp;
   logic [63:0] rpc_exp;
   bit          last_acc;
   bit          chk_en = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Sign-extend a field of the given width using integer arithmetic.
   function automatic longint sx(longint raw, int bits);
      longint half = longint'(1) <<< (bits - 1);
      return (raw >= half) ? raw - (half <<< 1) : raw;
   endfunction

   function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] p);
      exp_t   e;
      byte    k;
      longint v;
      e = '{default: 0};
      e.opcode = ins[6:0];
      e.func3  = ins[14:12];
      e.func7  = ins[30];
      e.pc     = {32'h0, p};
      case (ins[6:0])
         7'h37, 7'h17:               k = "U";
         7'h6F:                      k = "J";
         7'h67, 7'h03, 7'h13, 7'h73: k = "I";
         7'h63:                      k = "B";
         7'h23:                      k = "S";
         7'h33:                      k = "R";
         7'h1B:                      k = (XLEN == 64) ? "I" : "X";
         7'h3B:                      k = (XLEN == 64) ? "R" : "X";
         default:                    k = "X";
      endcase
`ifndef YSYX_22041412_RVM_EN
      if (k == "R" && ins[31:25] == 7'b0000001) k = "X";
`endif
      if (k == "X") begin
         e.illegal = 1;
         return e;
      end
      e.rs1 = (k == "U" || k == "J") ? 5'd0 : ins[19:15];
      e.rs2 = (k == "R" || k == "S" || k == "B") ? ins[24:20] : 5'd0;
      e.rd  = (k == "S" || k == "B") ? 5'd0 : ins[11:7];
      case (k)
         "I":     v = sx(longint'(ins[31:20]), 12);
         "S":     v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
         "B":     v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                     longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
         "U":     v = sx(longint'(ins[31:12]) * 4096, 32);
         "J":     v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                     longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
         default: v = 0;
      endcase
      e.imm = 64'(v);
      e.v2  = (k == "R" || k == "B") ? 1'b0 : 1'b1;
      if (ins[6:0] == 7'h17 || ins[6:0] == 7'h6F)  e.v1 = 2'b01;
      else if (ins[6:0] == 7'h73 && ins[14])       e.v1 = 2'b10;
      if (ins[6:0] == 7'h03) e.mem = 2'b01;
      if (ins[6:0] == 7'h23) e.mem = 2'b10;
      if (ins[6:0] == 7'h6F) e.jmp = 2'b01;
      if (ins[6:0] == 7'h67) e.jmp = 2'b10;
      if (ins[6:0] == 7'h63) e.jmp = 2'b11;
      if (ins[6:0] == 7'h1B) e.rv64 = 2'b01;
      if (ins[6:0] == 7'h3B) e.rv64 = 2'b10;
`ifdef YSYX_22041412_RVM_EN
      if (k == "R" && ins[25]) begin
         if (ins[14]) e.div = 1;
         else         e.mul = 1;
      end
`endif
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      rv_exp  = 0;
      rpc_exp = '0;
   endtask

   // Advance the model over one rising edge, using the inputs the bench drove.
   task automatic model_step();
      exp_t d;
      bit   acc, drn;
      d   = ref_decode(bus.instr, bus.pc);
      acc = bus.in_valid && (q.size() < 2) && !bus.flush;
      drn = (q.size() > 0) && bus.out_ready && !bus.flush;
      rv_exp = acc && (d.jmp == 2'b01) && !d.illegal;
      if (rv_exp) rpc_exp = d.pc + d.imm;
      if (bus.flush) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(d);
      end
      last_acc = acc;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", bus.in_ready, q.size() < 2);
         chk("out_valid", bus.out_valid, q.size() != 0);
         chk("redirect_valid", bus.redirect_valid, rv_exp);
         chk("redirect_pc", bus.redirect_pc, rpc_exp);
         if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("opcode", bus.opcode, q[0].opcode);
            chk("func3", bus.func3, q[0].func3);
            chk("func7", bus.func7, q[0].func7);
            chk("rs1", bus.rs1, q[0].rs1);
            chk("rs2", bus.rs2, q[0].rs2);
            chk("rd", bus.rd, q[0].rd);
            chk("imm", bus.imm, q[0].imm);
            chk("v1type", bus.v1type, q[0].v1);
            chk("v2type", bus.v2type, q[0].v2);
            chk("mul_en", bus.mul_en, q[0].mul);
            chk("div_en", bus.div_en, q[0].div);
            chk("rv64_en", bus.rv64_en, q[0].rv64);
            chk("mem_mode", bus.mem_mode, q[0].mem);
            chk("jump_mode", bus.jump_mode, q[0].jmp);
            chk("illegal", bus.illegal, q[0].illegal);
         end
      end
   end

   task automatic drv(bit v, logic [31:0] i, logic [31:0] p, bit f, bit r);
      bus.in_valid  = v;
      bus.instr     = i;
      bus.pc        = p;
      bus.flush     = f;
      bus.out_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0]  opl [16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                7'h33, 7'h73, 7'h1B, 7'h3B, 7'h00, 7'h0F, 7'h2F, 7'h7F};
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opl[$urandom_range(0, 15)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h3B) && $urandom_range(0, 2) == 0)
         w[31:25] = 7'b0000001;
      return w;
   endfunction

   initial begin
      logic [31:0] s_ins [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
      logic [31:0] s_pc  [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
      logic [63:0] got[$];
      int idx;

      rst = 1'b1;
      drv(0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_redirect_valid", bus.redirect_valid, 0);
      chk("rst_redirect_pc", bus.redirect_pc, 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      rst = 1'b0;
      chk_en = 1;

      // addi x1,x0,5
      drv(1, 32'h00500093, 32'h80000000, 0, 1); tick();
      chk("addi_out_valid", bus.out_valid, 1);
      chk("addi_rd", bus.rd, 1);
      chk("addi_rs1", bus.rs1, 0);
      chk("addi_rs2", bus.rs2, 0);
      chk("addi_imm", bus.imm, 5);
      chk("addi_v2type", bus.v2type, 1);
      chk("addi_illegal", bus.illegal, 0);
      drv(0, 0, 0, 0, 1); tick();

      // jal x1,+8; redirect pulse must last one cycle even while stalled
      drv(1, 32'h008000EF, 32'h80000000, 0, 1); tick();
      chk("jal_redirect_valid", bus.redirect_valid, 1);
      chk("jal_redirect_pc", bus.redirect_pc, 64'h80000008);
      chk("jal_jump_mode", bus.jump_mode, 2'b01);
      chk("jal_rd", bus.rd, 1);
      drv(0, 0, 0, 0, 0); tick();
      chk("jal_pulse_end", bus.redirect_valid, 0);
      chk("jal_pc_held", bus.redirect_pc, 64'h80000008);
      drv(0, 0, 0, 0, 1); tick();

      // stream of four with out_ready low during cycles 2-4
      idx = 0;
      for (int c = 1; c <= 10; c++) begin
         drv(idx < 4, s_ins[(idx < 4) ? idx : 0], s_pc[(idx < 4) ? idx : 0], 0, !(c >= 2 && c <= 4));
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_pc);
         tick();
         if (last_acc) idx++;
         if (c == 2) chk("stream_in_ready_low", bus.in_ready, 0);
      end
      chk("stream_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk("stream_order", got[i], 64'(s_pc[i]));

      // two held, then flush with a valid input that must vanish
      drv(1, 32'h00A00513, 32'h200, 0, 0); tick();
      drv(1, 32'h00B00593, 32'h204, 0, 0); tick();
      chk("flush_pre_full", bus.in_ready, 0);
      drv(1, 32'h00C00613, 32'h208, 1, 1); tick();
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_in_ready", bus.in_ready, 1);
      drv(0, 0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("flush_no_ghost", bus.out_valid, 0);
      end

      // all-zero word
      drv(1, 32'h00000000, 32'h300, 0, 1); tick();
      chk("zero_illegal", bus.illegal, 1);
      chk("zero_mem_mode", bus.mem_mode, 0);
      chk("zero_jump_mode", bus.jump_mode, 0);

      // mul a0,a0,a1
      drv(1, 32'h02B50533, 32'h304, 0, 1); tick();
`ifdef YSYX_22041412_RVM_EN
      chk("mul_mul_en", bus.mul_en, 1);
      chk("mul_illegal", bus.illegal, 0);
`else
      chk("mul_illegal", bus.illegal, 1);
      chk("mul_mul_en", bus.mul_en, 0);
`endif
      drv(0, 0, 0, 0, 1); tick();

      // asynchronous reset with two entries held
      drv(1, 32'h00100093, 32'h400, 0, 0); tick();
      drv(1, 32'h00200093, 32'h404, 0, 0); tick();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drv($urandom_range(0, 9) < 7, gen_instr(), $urandom, $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 6);
         tick();
      end

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
